// File: rtl/pixel_fetch_scheduler_if.sv
// Line-fetch handshake between the display scheduler (master) and the memory side (slave).
interface pixel_fetch_scheduler_if;
    localparam int unsigned LINE_W = 10;

    logic              fetch_req;
    logic [LINE_W-1:0] fetch_line;
    logic              fetch_bank;
    logic              fetch_ack;

    modport master (output fetch_req, output fetch_line, output fetch_bank, input fetch_ack);
    modport slave  (input fetch_req, input fetch_line, input fetch_bank, output fetch_ack);
endinterface

// File: rtl/pixel_fetch_scheduler.sv
// Schedules ping-pong line-buffer fetches for 2x vertical/horizontal pixel replication
// and drives the line-buffer read side; flags underruns when a line is not ready in time.
module pixel_fetch_scheduler #(
    parameter int unsigned HACTIVE   = 640,
    parameter int unsigned VACTIVE   = 480,
    parameter int unsigned SRC_LINES = 240,
    localparam int unsigned CNT_W    = 11,
    localparam int unsigned LINE_W   = 10,
    localparam int unsigned ADDR_W   = 9
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic [CNT_W-1:0]  in_hcnt,
    input  logic [CNT_W-1:0]  in_vcnt,
    input  logic              in_blank,
    pixel_fetch_scheduler_if.master fetch,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              vblank_start,
    output logic              underrun,
    input  logic              underrun_clr
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state_q, state_d;
    logic              req_q;
    logic [LINE_W-1:0] line_q, line_d;
    logic              bank_q, bank_d;
    logic [1:0]        valid_q, valid_d;
    logic              underrun_q, underrun_d;

    logic              active_c, line_start_c, line_end_c;
    logic              prefetch_c, line_trig_c, trig_c;
    logic [LINE_W-1:0] src_line_c, trig_line_c;
    logic [CNT_W-1:0]  next_src_c;

    // Timing decode: source line s = v>>1, triggers at line start/end and top of vblank
    assign active_c     = in_vcnt < CNT_W'(VACTIVE);
    assign line_start_c = active_c && (in_hcnt == '0);
    assign line_end_c   = active_c && (in_hcnt == CNT_W'(HACTIVE));
    assign src_line_c   = in_vcnt[CNT_W-1:1];
    assign next_src_c   = {1'b0, src_line_c} + CNT_W'(1);
    assign prefetch_c   = (in_vcnt == CNT_W'(VACTIVE)) && (in_hcnt == '0);
    assign line_trig_c  = line_end_c && !in_vcnt[0] && (next_src_c < CNT_W'(SRC_LINES));
    assign trig_c       = prefetch_c || line_trig_c;
    assign trig_line_c  = prefetch_c ? '0 : next_src_c[LINE_W-1:0];

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        bank_d     = bank_q;
        valid_d    = valid_q;
        underrun_d = underrun_q;

        if (underrun_clr) underrun_d = 1'b0;
        // Bank is consumed after the second (odd) display line of its source line
        if (line_end_c && in_vcnt[0]) valid_d[src_line_c[0]] = 1'b0;
        if (line_start_c && !valid_q[src_line_c[0]]) underrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (trig_c) begin
                    state_d = REQ;
                    line_d  = trig_line_c;
                    bank_d  = trig_line_c[0];
                end
            end
            REQ: begin
                if (fetch.fetch_ack) begin
                    valid_d[bank_q] = 1'b1;
                    if (trig_c) begin
                        line_d = trig_line_c;
                        bank_d = trig_line_c[0];
                    end else begin
                        state_d = IDLE;
                    end
                end else if (trig_c) begin
                    // Previous line still outstanding: drop the new trigger
                    underrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            line_q       <= '0;
            bank_q       <= 1'b0;
            valid_q      <= '0;
            underrun_q   <= 1'b0;
            rd_en        <= 1'b0;
            rd_bank      <= 1'b0;
            rd_addr      <= '0;
            vblank_start <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= (state_d == REQ);
            line_q       <= line_d;
            bank_q       <= bank_d;
            valid_q      <= valid_d;
            underrun_q   <= underrun_d;
            rd_en        <= ~in_blank;
            rd_bank      <= in_vcnt[1];
            rd_addr      <= in_hcnt[ADDR_W:1];
            vblank_start <= prefetch_c;
        end
    end

    assign fetch.fetch_req  = req_q;
    assign fetch.fetch_line = line_q;
    assign fetch.fetch_bank = bank_q;
    assign underrun         = underrun_q;

endmodule

// File: tb/tb_pixel_fetch_scheduler.sv
// Bench for pixel_fetch_scheduler: directed cases plus randomized frames against a behavioural model.
module tb_pixel_fetch_scheduler;
    localparam int unsigned HACTIVE   = 16;
    localparam int unsigned VACTIVE   = 12;
    localparam int unsigned SRC_LINES = 6;
    localparam int unsigned HTOTAL    = 24;
    localparam int unsigned VTOTAL    = 16;

    logic        pclk = 1'b0;
    logic        reset_n;
    logic [10:0] in_hcnt, in_vcnt;
    logic        in_blank;
    logic        rd_en, rd_bank;
    logic [8:0]  rd_addr;
    logic        vblank_start, underrun, underrun_clr;
    logic        auto_pulse = 1'b0;
    logic        man_ack = 1'b0;

    always #5 pclk = ~pclk;

    pixel_fetch_scheduler_if bus();
    assign bus.fetch_ack = auto_pulse | man_ack;

    pixel_fetch_scheduler #(.HACTIVE(HACTIVE), .VACTIVE(VACTIVE), .SRC_LINES(SRC_LINES)) u_dut (
        .pclk(pclk), .reset_n(reset_n), .in_hcnt(in_hcnt), .in_vcnt(in_vcnt),
        .in_blank(in_blank), .fetch(bus), .rd_en(rd_en), .rd_bank(rd_bank),
        .rd_addr(rd_addr), .vblank_start(vblank_start), .underrun(underrun),
        .underrun_clr(underrun_clr)
    );

    // Behavioural model: one outstanding request, two bank-ready flags, sticky error
    typedef struct packed {
        logic       req;
        logic [9:0] line;
        logic       bank;
        logic [1:0] valid;
        logic       ur;
        logic       rd_en;
        logic       rd_bank;
        logic [8:0] rd_addr;
        logic       vbs;
    } model_t;

    model_t m;

    function automatic model_t model_next(input model_t c, input int unsigned h, input int unsigned v,
                                          input logic blank, input logic ack, input logic clr);
        model_t      n;
        int unsigned s;
        int unsigned tline;
        logic        sb, active, pre, ltrig;
        n      = c;
        s      = v / 2;
        sb     = 1'(s % 2);
        active = v < VACTIVE;
        pre    = (v == VACTIVE) && (h == 0);
        ltrig  = active && (h == HACTIVE) && (v % 2 == 0) && (s + 1 < SRC_LINES);
        tline  = pre ? 0 : s + 1;
        if (active && h == HACTIVE && v % 2 == 1) n.valid[sb] = 1'b0;
        if (c.req && ack) n.valid[c.bank] = 1'b1;
        n.ur = clr ? 1'b0 : c.ur;
        if (active && h == 0 && !c.valid[sb]) n.ur = 1'b1;
        if ((pre || ltrig) && c.req && !ack) n.ur = 1'b1;
        if (!(c.req && !ack)) begin
            if (pre || ltrig) begin
                n.req  = 1'b1;
                n.line = 10'(tline);
                n.bank = 1'(tline % 2);
            end else begin
                n.req = 1'b0;
            end
        end
        n.rd_en   = !blank;
        n.rd_bank = sb;
        n.rd_addr = 9'(h / 2);
        n.vbs     = pre;
        return n;
    endfunction

    always @(posedge pclk or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else m <= model_next(m, 32'(in_hcnt), 32'(in_vcnt), in_blank, bus.fetch_ack, underrun_clr);
    end

    // Memory-side responder: acks each request after a random latency, optional stray acks
    bit          auto_en  = 1'b0;
    bit          stray_en = 1'b0;
    int unsigned ack_max  = 20;
    int unsigned wait_cnt = 1;

    always @(negedge pclk) begin
        if (!auto_en) begin
            auto_pulse <= 1'b0;
            wait_cnt   <= $urandom_range(1, ack_max);
        end else if (bus.fetch_req && wait_cnt == 0) begin
            auto_pulse <= 1'b1;
            wait_cnt   <= $urandom_range(1, ack_max);
        end else begin
            auto_pulse <= stray_en && ($urandom_range(0, 31) == 0);
            if (bus.fetch_req) wait_cnt <= wait_cnt - 1;
            else wait_cnt <= $urandom_range(1, ack_max);
        end
    end

    int errors = 0;
    int checks = 0;
    bit track_en = 1'b0;
    bit prev_req = 1'b0;
    int exp_next = 0;
    int req_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("fetch_req",    32'(bus.fetch_req),  32'(m.req));
        chk("fetch_line",   32'(bus.fetch_line), 32'(m.line));
        chk("fetch_bank",   32'(bus.fetch_bank), 32'(m.bank));
        chk("rd_en",        32'(rd_en),          32'(m.rd_en));
        chk("rd_bank",      32'(rd_bank),        32'(m.rd_bank));
        chk("rd_addr",      32'(rd_addr),        32'(m.rd_addr));
        chk("vblank_start", 32'(vblank_start),   32'(m.vbs));
        chk("underrun",     32'(underrun),       32'(m.ur));
        // In a clean frame requests must walk lines 0..SRC_LINES-1 with alternating banks
        if (track_en && bus.fetch_req && (!prev_req || bus.fetch_ack)) begin
            chk("req_order_line", 32'(bus.fetch_line), exp_next);
            chk("req_order_bank", 32'(bus.fetch_bank), exp_next % 2);
            exp_next++;
            req_seen++;
        end
        prev_req = bus.fetch_req;
    endtask

    function automatic bit blank_of(input int unsigned h, input int unsigned v);
        return !(h < HACTIVE && v < VACTIVE);
    endfunction

    task automatic cyc_b(input int unsigned h, input int unsigned v, input bit blank,
                         input bit ack, input bit clr);
        @(negedge pclk);
        in_hcnt      = 11'(h);
        in_vcnt      = 11'(v);
        in_blank     = blank;
        man_ack      = ack;
        underrun_clr = clr;
        @(posedge pclk);
        #1;
        compare();
    endtask

    task automatic cyc(input int unsigned h, input int unsigned v, input bit ack, input bit clr);
        cyc_b(h, v, blank_of(h, v), ack, clr);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        reset_n      = 1'b0;
        man_ack      = 1'b0;
        underrun_clr = 1'b0;
        in_hcnt      = 11'(HTOTAL - 1);
        in_vcnt      = 11'(VTOTAL - 1);
        in_blank     = 1'b1;
        repeat (2) @(negedge pclk);
        reset_n  = 1'b1;
        prev_req = 1'b0;
    endtask

    task automatic run_frame(input bit clr_en);
        for (int vi = 0; vi < int'(VTOTAL); vi++) begin
            for (int h = 0; h < int'(HTOTAL); h++) begin
                cyc(h, (VACTIVE + vi) % VTOTAL, 1'b0, clr_en && ($urandom_range(0, 63) == 0));
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        in_hcnt      = '0;
        in_vcnt      = '0;
        in_blank     = 1'b1;
        underrun_clr = 1'b0;
        do_reset();
        chk("rst_fetch_req", 32'(bus.fetch_req), 0);
        chk("rst_fetch_line", 32'(bus.fetch_line), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_rd_en", 32'(rd_en), 0);

        // Prefetch at the top of vertical blank
        cyc(0, VACTIVE, 1'b0, 1'b0);
        chk("pre_vbs", 32'(vblank_start), 1);
        chk("pre_req", 32'(bus.fetch_req), 1);
        chk("pre_line", 32'(bus.fetch_line), 0);
        chk("pre_bank", 32'(bus.fetch_bank), 0);
        cyc(1, VACTIVE, 1'b0, 1'b0);
        chk("pre_vbs_once", 32'(vblank_start), 0);
        chk("pre_req_hold", 32'(bus.fetch_req), 1);
        for (int h = 2; h < 5; h++) cyc(h, VACTIVE, 1'b0, 1'b0);
        cyc(5, VACTIVE, 1'b1, 1'b0);
        chk("pre_ack_drop", 32'(bus.fetch_req), 0);

        // Read-side mapping
        cyc_b(320, 10, 1'b0, 1'b0, 1'b0);
        chk("rd_en_lit", 32'(rd_en), 1);
        chk("rd_bank_lit", 32'(rd_bank), 1);
        chk("rd_addr_lit", 32'(rd_addr), 160);

        // Missing line, suppressed last trigger, trigger while busy, clear priority
        do_reset();
        cyc(HACTIVE, 8, 1'b0, 1'b0);
        chk("l5_line", 32'(bus.fetch_line), 5);
        chk("l5_bank", 32'(bus.fetch_bank), 1);
        cyc(HACTIVE, 10, 1'b0, 1'b0);
        chk("last_suppr_ur", 32'(underrun), 0);
        chk("last_suppr_line", 32'(bus.fetch_line), 5);
        cyc(0, 10, 1'b0, 1'b0);
        chk("ur_set", 32'(underrun), 1);
        cyc(1, 10, 1'b0, 1'b1);
        chk("ur_clr", 32'(underrun), 0);
        cyc(HACTIVE, 6, 1'b0, 1'b0);
        chk("busy_trig_ur", 32'(underrun), 1);
        chk("busy_trig_line", 32'(bus.fetch_line), 5);
        cyc(0, 10, 1'b0, 1'b1);
        chk("ur_set_beats_clr", 32'(underrun), 1);
        cyc(2, 10, 1'b0, 1'b1);
        chk("ur_clr2", 32'(underrun), 0);

        // Ack coincident with the next trigger
        do_reset();
        cyc(HACTIVE, 6, 1'b0, 1'b0);
        chk("l4_line", 32'(bus.fetch_line), 4);
        cyc(HACTIVE, 8, 1'b1, 1'b0);
        chk("sim_req", 32'(bus.fetch_req), 1);
        chk("sim_line", 32'(bus.fetch_line), 5);
        chk("sim_bank", 32'(bus.fetch_bank), 1);
        chk("sim_ur", 32'(underrun), 0);
        cyc(3, 8, 1'b0, 1'b0);

        // Asynchronous reset mid-request, then a stale ack
        @(negedge pclk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(bus.fetch_req), 0);
        chk("async_rst_line", 32'(bus.fetch_line), 0);
        @(negedge pclk);
        reset_n  = 1'b1;
        prev_req = 1'b0;
        cyc(3, VACTIVE + 1, 1'b1, 1'b0);
        chk("stale_ack_req", 32'(bus.fetch_req), 0);
        cyc(4, VACTIVE + 1, 1'b0, 1'b0);
        chk("stale_ack_ur", 32'(underrun), 0);

        // Clean frames: timely acks, no underrun, SRC_LINES ordered requests per frame
        do_reset();
        ack_max  = 20;
        stray_en = 1'b0;
        auto_en  = 1'b1;
        track_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            exp_next = 0;
            req_seen = 0;
            run_frame(1'b0);
            chk("frame_reqs", req_seen, SRC_LINES);
            chk("frame_underrun", 32'(underrun), 0);
        end
        track_en = 1'b0;

        // Stress: slow and stray acks, random clears, then random counter values
        ack_max  = 60;
        stray_en = 1'b1;
        for (int f = 0; f < 10; f++) run_frame(1'b1);
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, HTOTAL - 1), $urandom_range(0, VTOTAL - 1), 1'b0,
                $urandom_range(0, 15) == 0);
        end
        auto_en  = 1'b0;
        stray_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_fetch_scheduler.md
PIXEL_FETCH_SCHEDULER -- requirements
Module: pixel_fetch_scheduler

Interface
REQ-001 Parameter HACTIVE, default 640, SHALL set the active display width in pixels.
REQ-002 Parameter VACTIVE, default 480, SHALL set the active display height in lines.
REQ-003 Parameter SRC_LINES, default 240 (VACTIVE/2), SHALL set the number of source lines per frame.
REQ-004 pclk  in  1  pixel clock, rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 in_hcnt  in  11  horizontal counter from the timing generator.
REQ-007 in_vcnt  in  11  vertical counter from the timing generator.
REQ-008 in_blank  in  1  blanking flag from the timing generator.
REQ-009 fetch_req  out  1  line-fetch request to the memory side.
REQ-010 fetch_line  out  10  source line index to fetch.
REQ-011 fetch_bank  out  1  target ping-pong line-buffer bank.
REQ-012 fetch_ack  in  1  one-cycle pulse: the requested line is fully written.
REQ-013 rd_en  out  1  line-buffer read enable.
REQ-014 rd_bank  out  1  line-buffer bank to read.
REQ-015 rd_addr  out  9  source pixel address within the line.
REQ-016 vblank_start  out  1  one-cycle pulse at the start of vertical blank.
REQ-017 underrun  out  1  sticky error flag.
REQ-018 underrun_clr  in  1  clears underrun.

Function
REQ-019 Mapping SHALL be 2x replication: display line v reads source line s=v>>1 from bank s[0] at address in_hcnt>>1.
REQ-020 rd_en SHALL equal ~in_blank, and rd_bank/rd_addr SHALL follow in_vcnt/in_hcnt, all registered with a latency of 1 pclk.
REQ-021 The FSM SHALL have two states, IDLE and REQ; fetch_req SHALL be high only in REQ.
REQ-022 Prefetch trigger: in_vcnt==VACTIVE and in_hcnt==0 SHALL issue fetch_line=0, fetch_bank=0, and pulse vblank_start in the same cycle.
REQ-023 Line trigger: in_hcnt==HACTIVE on an even active line v=2s with s+1<SRC_LINES SHALL issue fetch_line=s+1, fetch_bank=(s+1)[0].
REQ-024 The trigger SHALL be suppressed for s+1==SRC_LINES (display line 478 at defaults); no fetch is issued for line 240.
REQ-025 On a trigger, the FSM SHALL move IDLE->REQ on the next edge, with fetch_line and fetch_bank loaded on the same edge.
REQ-026 fetch_req, fetch_line and fetch_bank SHALL hold stable until fetch_ack is sampled high in REQ.
REQ-027 fetch_ack in REQ SHALL move the FSM to IDLE and set bank_valid[fetch_bank]; fetch_ack in IDLE SHALL be ignored.
REQ-028 On a simultaneous fetch_ack and trigger in REQ, the block SHALL accept the ack, stay in REQ with the new line/bank, and SHALL NOT flag underrun.
REQ-029 A trigger in REQ without fetch_ack SHALL set underrun, drop the new trigger, and keep the outstanding request.
REQ-030 bank_valid[b] SHALL clear at in_hcnt==HACTIVE on odd active line 2s+1 with s[0]==b.
REQ-031 If an ack sets and a line end clears the same bank in one cycle, set SHALL win.
REQ-032 At in_hcnt==0 on an active line, underrun SHALL be set if bank_valid[(in_vcnt>>1)[0]]==0.
REQ-033 underrun_clr SHALL clear underrun; an underrun event in the same cycle as underrun_clr SHALL win.
REQ-034 Counter wrap to 0 SHALL need no special handling; the block SHALL react only to the compared values.

Reset
REQ-035 reset_n low SHALL asynchronously force state IDLE and clear fetch_req, fetch_line, fetch_bank, rd_en, rd_bank, rd_addr, vblank_start, underrun and bank_valid to 0.
REQ-036 Reset mid-request SHALL drop fetch_req immediately; after release the block SHALL wait for the next trigger and ignore any stale fetch_ack.
REQ-037 After reset release mid-frame, underrun MAY set on the first active line; this is expected and clearable.

Verification
REQ-038 Reset, then drive counters to vcnt=480, hcnt=0 -> vblank_start pulses once; next cycle fetch_req=1, fetch_line=0, fetch_bank=0; ack after 5 cycles -> fetch_req=0.
REQ-039 Full frame with ack 100 cycles after each request -> 240 requests, lines 0..239, banks alternating; underrun stays 0; no request on line 478.
REQ-040 vcnt=10, hcnt=320 -> rd_en=1, rd_bank=1, rd_addr=160 one cycle later.
REQ-041 Withhold ack for line 5 past display line 10, hcnt=0 -> underrun=1; pulse underrun_clr -> underrun=0.
REQ-042 Assert fetch_ack in the same cycle as the line-4 trigger -> fetch_req stays high, fetch_line=5, underrun=0.
REQ-043 Assert reset_n low while fetch_req=1 -> fetch_req=0 with no clock edge; a stray fetch_ack after release -> no state change.
